// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM and the datapath mux/NPC select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_SLL, I_JR, I_J, I_JAL, I_BEQ,
    I_ADDIU, I_ORI, I_LUI, I_LW, I_SW, I_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] WD_ALU   = 3'b000;
  localparam logic [2:0] WD_DM    = 3'b001;
  localparam logic [2:0] WD_PC4   = 3'b010;
  localparam logic [2:0] WD_LUI   = 3'b011;
  localparam logic [2:0] WD_SHIFT = 3'b100;

  localparam logic [1:0] WR_RD = 2'b00;
  localparam logic [1:0] WR_RT = 2'b01;
  localparam logic [1:0] WR_RA = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  function automatic logic [2:0] alu_op_of(iclass_t c);
    case (c)
      I_SUBU, I_BEQ: return ALU_SUB;
      I_SLT:         return ALU_SLT;
      I_ORI:         return ALU_OR;
      default:       return ALU_ADD;
    endcase
  endfunction

  function automatic logic uses_imm(iclass_t c);
    return c inside {I_ADDIU, I_ORI, I_LUI, I_LW, I_SW};
  endfunction

  // ori and lui take the immediate unsigned; branch offsets and addresses are signed
  function automatic logic sign_ext(iclass_t c);
    return c inside {I_ADDIU, I_LW, I_SW, I_BEQ};
  endfunction

  function automatic logic is_rtype(iclass_t c);
    return c inside {I_ADDU, I_SUBU, I_SLT, I_SLL, I_JR};
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational opcode/funct decoder: maps the IR fields to an instruction class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass = I_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = I_ADDU;
          FN_SUBU: iclass = I_SUBU;
          FN_SLT:  iclass = I_SLT;
          FN_SLL:  iclass = I_SLL;
          FN_JR:   iclass = I_JR;
          default: iclass = I_ILL;
        endcase
      end
      OP_J:     iclass = I_J;
      OP_JAL:   iclass = I_JAL;
      OP_BEQ:   iclass = I_BEQ;
      OP_ADDIU: iclass = I_ADDIU;
      OP_ORI:   iclass = I_ORI;
      OP_LUI:   iclass = I_LUI;
      OP_LW:    iclass = I_LW;
      OP_SW:    iclass = I_SW;
      default:  iclass = I_ILL;
    endcase
  end

  assign illegal = (iclass == I_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB).
// Optional performance counters enabled by defining MC_PERF_CNT_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WD_W  = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             gpr_we,
  output logic             dm_req,
  output logic             dm_we,
  output logic [WD_W-1:0]  wd_sel,
  output logic [1:0]       wr_sel,
  output logic [2:0]       alu_op,
  output logic             b_sel,
  output logic             ext_op,
  output logic [1:0]       npc_op,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state, state_nx;
  iclass_t    iclass;
  logic       dec_illegal;
  logic [2:0] wd;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nx;
  end

  // Every output stays at its default while rst is low, so reset kills enables in the same cycle
  always_comb begin
    state_nx = state;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    gpr_we   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    wd       = WD_ALU;
    wr_sel   = WR_RD;
    alu_op   = ALU_ADD;
    b_sel    = 1'b0;
    ext_op   = 1'b0;
    npc_op   = NPC_PC4;
    illegal  = 1'b0;
    if (rst) begin
      unique case (state)
        S_FETCH: begin
          pc_we    = 1'b1;
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end
        S_DECODE: begin
          if (dec_illegal) begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            case (iclass)
              I_J: begin
                pc_we    = 1'b1;
                npc_op   = NPC_J;
                state_nx = S_FETCH;
              end
              I_JAL: begin
                pc_we    = 1'b1;
                npc_op   = NPC_J;
                gpr_we   = 1'b1;
                wr_sel   = WR_RA;
                wd       = WD_PC4;
                state_nx = S_FETCH;
              end
              default: state_nx = S_EXE;
            endcase
          end
        end
        S_EXE: begin
          alu_op = alu_op_of(iclass);
          b_sel  = uses_imm(iclass);
          ext_op = sign_ext(iclass);
          case (iclass)
            I_JR: begin
              pc_we    = 1'b1;
              npc_op   = NPC_JR;
              state_nx = S_FETCH;
            end
            I_BEQ: begin
              pc_we    = zero;
              npc_op   = NPC_BR;
              state_nx = S_FETCH;
            end
            I_LW:    state_nx = S_MEM_RD;
            I_SW:    state_nx = S_MEM_WR;
            default: state_nx = S_WB;
          endcase
        end
        S_MEM_RD: begin
          dm_req = 1'b1;
          if (dm_ready) state_nx = S_WB;
        end
        S_MEM_WR: begin
          dm_req = 1'b1;
          dm_we  = 1'b1;
          if (dm_ready) state_nx = S_FETCH;
        end
        S_WB: begin
          gpr_we = 1'b1;
          case (iclass)
            I_LW:    wd = WD_DM;
            I_LUI:   wd = WD_LUI;
            I_SLL:   wd = WD_SHIFT;
            default: wd = WD_ALU;
          endcase
          wr_sel   = is_rtype(iclass) ? WR_RD : WR_RT;
          state_nx = S_FETCH;
        end
        default: state_nx = S_FETCH;
      endcase
    end
  end

  assign wd_sel = WD_W'(wd);

`ifdef MC_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_q, instr_q;

  // An illegal instruction returns to FETCH without retiring
  assign retire = (state != S_FETCH) && (state_nx == S_FETCH) && !illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench for mc_ctrl_fsm with a per-instruction cycle-sequence model.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       gpr_we;
    logic       dm_req;
    logic       dm_we;
    logic [2:0] wd;
    logic [1:0] wr;
    logic [2:0] alu;
    logic       b;
    logic       ext;
    logic [1:0] npc;
    logic       ill;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  rdy;
    logic  z;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, dm_ready;
  logic        pc_we, ir_we, gpr_we, dm_req, dm_we, b_sel, ext_op, illegal;
  logic [2:0]  wd_sel, alu_op;
  logic [1:0]  wr_sel, npc_op;
  logic [31:0] cycle_cnt, instr_cnt;

  outs_t       act, exp_o;
  logic        exp_valid = 1'b0;
  logic [31:0] cyc_m = 0, ins_m = 0, exp_cyc = 0, exp_ins = 0;
  int          vectors = 0, miscompares = 0;
  cyc_t        seq[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WD_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .dm_ready(dm_ready),
    .pc_we(pc_we), .ir_we(ir_we), .gpr_we(gpr_we), .dm_req(dm_req), .dm_we(dm_we),
    .wd_sel(wd_sel), .wr_sel(wr_sel), .alu_op(alu_op), .b_sel(b_sel), .ext_op(ext_op),
    .npc_op(npc_op), .illegal(illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  assign act = {pc_we, ir_we, gpr_we, dm_req, dm_we, wd_sel, wr_sel, alu_op, b_sel, ext_op,
                npc_op, illegal};

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic string name_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21: return "addu";
               6'h23: return "subu";
               6'h2a: return "slt";
               6'h00: return "sll";
               6'h08: return "jr";
               default: return "ill";
             endcase
      6'h02: return "j";
      6'h03: return "jal";
      6'h04: return "beq";
      6'h09: return "addiu";
      6'h0d: return "ori";
      6'h0f: return "lui";
      6'h23: return "lw";
      6'h2b: return "sw";
      default: return "ill";
    endcase
  endfunction

  function automatic cyc_t mk();
    cyc_t c;
    c = '0;
    c.rdy = 1'($urandom);
    c.z   = 1'($urandom);
    return c;
  endfunction

  // Expected output sequence of one instruction, one entry per clock cycle
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int waits,
                                input logic bz);
    string n;
    cyc_t  c;
    n = name_of(op, fn);
    seq.delete();
    c = mk(); c.o.pc_we = 1; c.o.ir_we = 1; seq.push_back(c);
    c = mk();
    if (n == "j")   begin c.o.pc_we = 1; c.o.npc = 2; seq.push_back(c); return; end
    if (n == "jal") begin
      c.o.pc_we = 1; c.o.npc = 2; c.o.gpr_we = 1; c.o.wr = 2; c.o.wd = 3'b010;
      seq.push_back(c); return;
    end
    if (n == "ill") begin c.o.ill = 1; seq.push_back(c); return; end
    seq.push_back(c);
    c = mk();
    c.o.alu = (n == "subu" || n == "beq") ? 3'd1 : (n == "ori") ? 3'd2 : (n == "slt") ? 3'd3 : 3'd0;
    c.o.b   = (n == "ori" || n == "addiu" || n == "lui" || n == "lw" || n == "sw");
    c.o.ext = (n == "addiu" || n == "lw" || n == "sw" || n == "beq");
    if (n == "jr")  begin c.o.pc_we = 1; c.o.npc = 3; seq.push_back(c); return; end
    if (n == "beq") begin c.z = bz; c.o.pc_we = bz; c.o.npc = 1; seq.push_back(c); return; end
    seq.push_back(c);
    if (n == "lw" || n == "sw") begin
      for (int i = 0; i <= waits; i++) begin
        c = mk(); c.o.dm_req = 1; c.o.dm_we = (n == "sw"); c.rdy = (i == waits);
        seq.push_back(c);
      end
      if (n == "sw") return;
    end
    c = mk();
    c.o.gpr_we = 1;
    c.o.wd = (n == "lw") ? 3'd1 : (n == "lui") ? 3'd3 : (n == "sll") ? 3'd4 : 3'd0;
    c.o.wr = (n == "addu" || n == "subu" || n == "slt" || n == "sll") ? 2'd0 : 2'd1;
    seq.push_back(c);
  endfunction

  task automatic drive(input cyc_t c);
    dm_ready = c.rdy; zero = c.z; exp_o = c.o;
    exp_cyc = cyc_m; exp_ins = ins_m; exp_valid = 1'b1;
    @(posedge clk); #1;
    cyc_m++;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int waits, input logic bz);
    build(op, fn, waits, bz);
    opcode = op; funct = fn;
    foreach (seq[i]) drive(seq[i]);
    if (name_of(op, fn) != "ill") ins_m++;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("outputs", 64'(act), 64'(exp_o));
`ifdef MC_PERF_CNT_EN
      check("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
      check("instr_cnt", 64'(instr_cnt), 64'(exp_ins));
`else
      check("cycle_cnt", 64'(cycle_cnt), 64'(0));
      check("instr_cnt", 64'(instr_cnt), 64'(0));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] top[15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                            6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h00};
    logic [5:0] tfn[15] = '{6'h21, 6'h23, 6'h2a, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3f};
    int k;

    // Literal pins on the model's latencies and key fields
    build(6'h00, 6'h21, 0, 0);
    check("model_addu_len", 64'(seq.size()), 64'd4);
    check("model_addu_wb", 64'({seq[3].o.gpr_we, seq[3].o.wd, seq[3].o.wr}), 64'b1_000_00);
    build(6'h23, 6'h00, 3, 0);
    check("model_lw_len", 64'(seq.size()), 64'd8);
    check("model_lw_wb", 64'({seq[7].o.gpr_we, seq[7].o.wd, seq[7].o.wr}), 64'b1_001_01);
    build(6'h03, 6'h00, 0, 0);
    check("model_jal", 64'(seq[1].o), 64'b1_0_1_0_0_010_10_000_0_0_10_0);
    build(6'h2b, 6'h00, 0, 0);
    check("model_sw_len", 64'(seq.size()), 64'd4);
    build(6'h04, 6'h00, 0, 1);
    check("model_beq_len", 64'(seq.size()), 64'd3);

    rst = 1'b0; opcode = '0; funct = '0; zero = 0; dm_ready = 0;
    exp_o = '0; exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run(6'h00, 6'h21, 0, 0);
    run(6'h23, 6'h00, 3, 0);
    run(6'h03, 6'h00, 0, 0);
    run(6'h04, 6'h00, 0, 0);
    run(6'h04, 6'h00, 0, 1);
    run(6'h3f, 6'h00, 0, 0);
    run(6'h00, 6'h3f, 0, 0);
    run(6'h00, 6'h00, 0, 0);
    run(6'h0f, 6'h00, 0, 0);
    run(6'h2b, 6'h00, 2, 0);

    // Reset asserted in the middle of an sw EXE cycle
    build(6'h2b, 6'h00, 0, 0);
    opcode = 6'h2b; funct = 6'h00;
    drive(seq[0]);
    drive(seq[1]);
    dm_ready = seq[2].rdy; zero = seq[2].z; exp_o = seq[2].o;
    exp_cyc = cyc_m; exp_ins = ins_m;
    @(negedge clk); #1;
    rst = 1'b0;
    exp_o = '0; cyc_m = 0; ins_m = 0; exp_cyc = 0; exp_ins = 0;
    #1;
    check("reset_outputs", 64'(act), 64'd0);
    check("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("reset_instr_cnt", 64'(instr_cnt), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    run(6'h00, 6'h21, 0, 0);

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 14);
      run(top[k], tfn[k], $urandom_range(0, 4), 1'($urandom));
    end

    exp_valid = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
